// File: rtl/sampled_change_monitor.sv
// sampled_change_monitor
// Registers the previous enabled sample of a watched bus and reports
// changed/rose/fell/stable for each new enabled sample. In the ARMED state
// it also checks a selectable expectation and raises a fail pulse when the
// expectation is violated. Samples taken before ARMED are compared but not
// checked, which gives the logic under observation a settling window after
// reset.
module sampled_change_monitor #(
    parameter int WIDTH = 1,
    parameter int SKIP  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] val,
    input  logic [1:0]       mode,
    output logic             out_valid,
    output logic             changed,
    output logic             rose,
    output logic             fell,
    output logic             stable,
    output logic             fail,
    output logic             fail_sticky,
    output logic [CNT_W-1:0] change_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    // skip_cnt counts samples taken so far; it must reach SKIP.
    localparam int SKW = (SKIP > 1) ? $clog2(SKIP + 1) : 1;
    // Value of skip_cnt on the sample that completes the skip window.
    localparam logic [SKW-1:0]   SKIP_LAST = SKW'(SKIP - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        NOPAST   = 2'd0,
        SKIPPING = 2'd1,
        ARMED    = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [SKW-1:0]   skip_cnt_reg;
    logic [SKW-1:0]   skip_cnt_next;
    logic [WIDTH-1:0] past_reg;

    logic             out_valid_reg;
    logic             changed_reg;
    logic             rose_reg;
    logic             fell_reg;
    logic             stable_reg;
    logic             fail_reg;
    logic             fail_sticky_reg;
    logic [CNT_W-1:0] change_cnt_reg;
    logic [CNT_W-1:0] fail_cnt_reg;

    logic             out_valid_next;
    logic             changed_next;
    logic             rose_next;
    logic             fell_next;
    logic             stable_next;
    logic             fail_next;
    logic             fail_sticky_next;
    logic [CNT_W-1:0] change_cnt_next;
    logic [CNT_W-1:0] fail_cnt_next;

    // Per-bit difference between the incoming value and the stored sample.
    logic [WIDTH-1:0] diff_bits;
    logic             cmp_changed;
    logic             cmp_rose;
    logic             cmp_fell;
    logic             has_past;
    logic             check_en;
    logic             violation;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_diff
            assign diff_bits[gi] = val[gi] ^ past_reg[gi];
        end
    endgenerate

    assign cmp_changed = |diff_bits;
    assign cmp_rose    = ~past_reg[0] &  val[0];
    assign cmp_fell    =  past_reg[0] & ~val[0];
    // A comparison is meaningful only once a past sample has been stored.
    assign has_past    = (state_reg != NOPAST);
    // Checking is decided by the state in which the sample is taken.
    assign check_en    = (state_reg == ARMED);

    // Expectation decode; mode travels with the sample it qualifies.
    always_comb begin
        violation = 1'b0;
        case (mode)
            2'd1:    violation = ~cmp_changed;
            2'd2:    violation = cmp_changed;
            2'd3:    violation = ~cmp_rose;
            default: violation = 1'b0;
        endcase
    end

    // Next-state logic: NOPAST -> (SKIPPING) -> ARMED, advancing only on enabled samples.
    always_comb begin
        state_next    = state_reg;
        skip_cnt_next = skip_cnt_reg;
        if (en) begin
            case (state_reg)
                NOPAST: begin
                    skip_cnt_next = SKW'(1);
                    state_next    = (SKIP > 1) ? SKIPPING : ARMED;
                end
                SKIPPING: begin
                    skip_cnt_next = skip_cnt_reg + SKW'(1);
                    if (skip_cnt_reg == SKIP_LAST) begin
                        state_next = ARMED;
                    end
                end
                ARMED: begin
                    state_next = ARMED;
                end
                default: begin
                    state_next    = NOPAST;
                    skip_cnt_next = '0;
                end
            endcase
        end
    end

    // Output and counter next values; all flag pulses drop on disabled cycles.
    always_comb begin
        out_valid_next   = en;
        changed_next     = en & has_past & cmp_changed;
        rose_next        = en & has_past & cmp_rose;
        fell_next        = en & has_past & cmp_fell;
        stable_next      = en & has_past & ~cmp_changed;
        fail_next        = en & check_en & violation;
        fail_sticky_next = fail_sticky_reg | fail_next;
        change_cnt_next  = change_cnt_reg;
        fail_cnt_next    = fail_cnt_reg;
        if (changed_next && (change_cnt_reg != CNT_MAX)) begin
            change_cnt_next = change_cnt_reg + CNT_W'(1);
        end
        if (fail_next && (fail_cnt_reg != CNT_MAX)) begin
            fail_cnt_next = fail_cnt_reg + CNT_W'(1);
        end
    end

    // State register and skip counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= NOPAST;
            skip_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            skip_cnt_reg <= skip_cnt_next;
        end
    end

    // Past sample, registered flags and saturating counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            past_reg        <= '0;
            out_valid_reg   <= 1'b0;
            changed_reg     <= 1'b0;
            rose_reg        <= 1'b0;
            fell_reg        <= 1'b0;
            stable_reg      <= 1'b0;
            fail_reg        <= 1'b0;
            fail_sticky_reg <= 1'b0;
            change_cnt_reg  <= '0;
            fail_cnt_reg    <= '0;
        end else begin
            if (en) begin
                past_reg <= val;
            end
            out_valid_reg   <= out_valid_next;
            changed_reg     <= changed_next;
            rose_reg        <= rose_next;
            fell_reg        <= fell_next;
            stable_reg      <= stable_next;
            fail_reg        <= fail_next;
            fail_sticky_reg <= fail_sticky_next;
            change_cnt_reg  <= change_cnt_next;
            fail_cnt_reg    <= fail_cnt_next;
        end
    end

    assign out_valid   = out_valid_reg;
    assign changed     = changed_reg;
    assign rose        = rose_reg;
    assign fell        = fell_reg;
    assign stable      = stable_reg;
    assign fail        = fail_reg;
    assign fail_sticky = fail_sticky_reg;
    assign change_cnt  = change_cnt_reg;
    assign fail_cnt    = fail_cnt_reg;

endmodule
